// File: rtl/text_cursor_ctrl.sv
// Write-side sequencer for the character display RAM: cursor tracking,
// control-character handling and a row-major full-screen clear.
module text_cursor_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ROWS           = 4,
  parameter int COLS           = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  input  logic [DATA_WIDTH-1:0]                    in_data,
  output logic                                     in_ready,
  input  logic                                     clr,
  output logic                                     ram_we,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] ram_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] ram_col,
  output logic [DATA_WIDTH-1:0]                    ram_din,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cur_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cur_col,
  output logic                                     busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(32'h08);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(32'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(32'h0C);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(32'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(32'h20);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(32'h7E);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state;
  logic   clr_pend;
  logic   xfer;
  logic   printable;

  // clr_pend holds a clear requested by reset release or an accepted FF;
  // it also blocks intake so no character is swallowed before the clear starts.
  assign in_ready  = (state == IDLE) && !clr && !clr_pend && reset;
  assign xfer      = in_valid && in_ready;
  assign printable = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_pend <= CLEAR_ON_RESET;
      ram_we   <= 1'b0;
      ram_row  <= '0;
      ram_col  <= '0;
      ram_din  <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ram_we <= 1'b0;
          if (clr || clr_pend) begin
            // The entry edge already issues the first clear write at (0,0).
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_pend <= 1'b0;
            ram_we   <= 1'b1;
            ram_row  <= '0;
            ram_col  <= '0;
            ram_din  <= '0;
          end else if (xfer) begin
            if (printable) begin
              ram_we  <= 1'b1;
              ram_row <= cur_row;
              ram_col <= cur_col;
              ram_din <= in_data;
              if (cur_col == COL_MAX) begin
                cur_col <= '0;
                cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
              end else begin
                cur_col <= cur_col + 1'b1;
              end
            end else begin
              case (in_data)
                CH_CR: cur_col <= '0;
                CH_LF: begin
                  cur_col <= '0;
                  cur_row <= (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
                end
                CH_BS: begin
                  if (cur_col != '0) begin
                    cur_col <= cur_col - 1'b1;
                    ram_we  <= 1'b1;
                    ram_row <= cur_row;
                    ram_col <= cur_col - 1'b1;
                    ram_din <= CH_SPACE;
                  end else if (cur_row != '0) begin
                    cur_row <= cur_row - 1'b1;
                    cur_col <= COL_MAX;
                    ram_we  <= 1'b1;
                    ram_row <= cur_row - 1'b1;
                    ram_col <= COL_MAX;
                    ram_din <= CH_SPACE;
                  end
                end
                CH_FF:   clr_pend <= 1'b1;
                default: ;
              endcase
            end
          end
        end

        CLEAR: begin
          // ram_row/ram_col double as the clear address counter.
          if (ram_row == ROW_MAX && ram_col == COL_MAX) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ram_we  <= 1'b0;
            cur_row <= '0;
            cur_col <= '0;
          end else begin
            ram_we  <= 1'b1;
            ram_din <= '0;
            if (ram_col == COL_MAX) begin
              ram_col <= '0;
              ram_row <= ram_row + 1'b1;
            end else begin
              ram_col <= ram_col + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
